// File: rtl/mem_stage.sv
// Memory-access stage: registers one instruction from execute, runs the load/store handshake, feeds write-back.
// Optional misaligned-access trap is enabled by defining MS_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int unsigned DM_ADDR_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 es_valid_i,
  output logic                 ms_allowin_o,
  input  logic [31:0]          es_alu_result_i,
  input  logic [31:0]          es_store_data_i,
  input  logic [5:0]           es_ctrl_i,
  input  logic [2:0]           es_funct3_i,
  input  logic [4:0]           es_rd_i,
  output logic                 ms_valid_o,
  output logic [31:0]          ms_mem_out_o,
  output logic [31:0]          ms_alu_result_o,
  output logic [5:0]           ms_ctrl_o,
  output logic [4:0]           ms_rd_o,
  output logic                 ms_misalign_o,
  output logic                 dm_req_o,
  output logic                 dm_we_o,
  output logic [DM_ADDR_W-1:0] dm_addr_o,
  output logic [3:0]           dm_wstrb_o,
  output logic [31:0]          dm_wdata_o,
  input  logic                 dm_ack_i,
  input  logic [31:0]          dm_rdata_i
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CTRL_W = 6;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned RD_W   = 5;

  typedef enum logic {IDLE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [F3_W-1:0]     f3_q, f3_d;
  logic [RD_W-1:0]     rd_q, rd_d;

  logic                ms_valid_q, ms_valid_d;
  logic                ms_misalign_q, ms_misalign_d;
  logic [XLEN-1:0]     ms_mem_out_q, ms_mem_out_d;
  logic [XLEN-1:0]     ms_alu_q, ms_alu_d;
  logic [CTRL_W-1:0]   ms_ctrl_q, ms_ctrl_d;
  logic [RD_W-1:0]     ms_rd_q, ms_rd_d;
  logic                dm_req_q, dm_req_d;
  logic                dm_we_q, dm_we_d;
  logic [DM_ADDR_W-1:0] dm_addr_q, dm_addr_d;
  logic [3:0]          dm_wstrb_q, dm_wstrb_d;
  logic [XLEN-1:0]     dm_wdata_q, dm_wdata_d;

  logic                is_mem_c;
  logic                misalign_c;
  logic [3:0]          st_strb_c;
  logic [XLEN-1:0]     st_data_c;
  logic [XLEN-1:0]     ld_word_c;
  logic [XLEN-1:0]     ld_fmt_c;

  assign is_mem_c = es_ctrl_i[2] | es_ctrl_i[3];

`ifdef MS_MISALIGN_CHECK_EN
  // funct3[1:0] encodes access size: 00 byte, 01 half, else word
  always_comb begin
    unique case (es_funct3_i[1:0])
      2'b00:   misalign_c = 1'b0;
      2'b01:   misalign_c = es_alu_result_i[0];
      default: misalign_c = |es_alu_result_i[1:0];
    endcase
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane replication and strobes from the incoming address
  always_comb begin
    unique case (es_funct3_i[1:0])
      2'b00: begin
        st_strb_c = 4'b0001 << es_alu_result_i[1:0];
        st_data_c = {4{es_store_data_i[7:0]}};
      end
      2'b01: begin
        st_strb_c = 4'b0011 << {es_alu_result_i[1], 1'b0};
        st_data_c = {2{es_store_data_i[15:0]}};
      end
      default: begin
        st_strb_c = 4'b1111;
        st_data_c = es_store_data_i;
      end
    endcase
  end

  // Load lane select shifts the addressed byte down to bit 0; upper lanes fill with zero
  assign ld_word_c = dm_rdata_i >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   ld_fmt_c = {{24{~f3_q[2] & ld_word_c[7]}}, ld_word_c[7:0]};
      2'b01:   ld_fmt_c = {{16{~f3_q[2] & ld_word_c[15]}}, ld_word_c[15:0]};
      default: ld_fmt_c = ld_word_c;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    ctrl_d        = ctrl_q;
    f3_d          = f3_q;
    rd_d          = rd_q;
    ms_valid_d    = 1'b0;
    ms_misalign_d = 1'b0;
    ms_ctrl_d     = '0;
    ms_mem_out_d  = ms_mem_out_q;
    ms_alu_d      = ms_alu_q;
    ms_rd_d       = ms_rd_q;
    dm_req_d      = dm_req_q;
    dm_we_d       = dm_we_q;
    dm_addr_d     = dm_addr_q;
    dm_wstrb_d    = dm_wstrb_q;
    dm_wdata_d    = dm_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (es_valid_i) begin
          addr_d = es_alu_result_i;
          ctrl_d = es_ctrl_i;
          f3_d   = es_funct3_i;
          rd_d   = es_rd_i;
          if (!is_mem_c) begin
            ms_valid_d = 1'b1;
            ms_ctrl_d  = es_ctrl_i;
            ms_alu_d   = es_alu_result_i;
            ms_rd_d    = es_rd_i;
          end else if (misalign_c) begin
            // Trapped access retires immediately without touching memory or the register file
            ms_valid_d    = 1'b1;
            ms_misalign_d = 1'b1;
            ms_ctrl_d     = {es_ctrl_i[CTRL_W-1:1], 1'b0};
            ms_mem_out_d  = '0;
            ms_alu_d      = es_alu_result_i;
            ms_rd_d       = es_rd_i;
          end else begin
            state_d    = WAIT;
            dm_req_d   = 1'b1;
            dm_we_d    = es_ctrl_i[3];
            dm_addr_d  = DM_ADDR_W'(es_alu_result_i);
            dm_wstrb_d = es_ctrl_i[3] ? st_strb_c : 4'b0000;
            dm_wdata_d = es_ctrl_i[3] ? st_data_c : '0;
          end
        end
      end
      WAIT: begin
        if (dm_ack_i) begin
          state_d      = IDLE;
          dm_req_d     = 1'b0;
          ms_valid_d   = 1'b1;
          ms_ctrl_d    = ctrl_q;
          ms_alu_d     = addr_q;
          ms_rd_d      = rd_q;
          ms_mem_out_d = ctrl_q[3] ? '0 : ld_fmt_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      ctrl_q        <= '0;
      f3_q          <= '0;
      rd_q          <= '0;
      ms_valid_q    <= 1'b0;
      ms_misalign_q <= 1'b0;
      ms_mem_out_q  <= '0;
      ms_alu_q      <= '0;
      ms_ctrl_q     <= '0;
      ms_rd_q       <= '0;
      dm_req_q      <= 1'b0;
      dm_we_q       <= 1'b0;
      dm_addr_q     <= '0;
      dm_wstrb_q    <= '0;
      dm_wdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      ctrl_q        <= ctrl_d;
      f3_q          <= f3_d;
      rd_q          <= rd_d;
      ms_valid_q    <= ms_valid_d;
      ms_misalign_q <= ms_misalign_d;
      ms_mem_out_q  <= ms_mem_out_d;
      ms_alu_q      <= ms_alu_d;
      ms_ctrl_q     <= ms_ctrl_d;
      ms_rd_q       <= ms_rd_d;
      dm_req_q      <= dm_req_d;
      dm_we_q       <= dm_we_d;
      dm_addr_q     <= dm_addr_d;
      dm_wstrb_q    <= dm_wstrb_d;
      dm_wdata_q    <= dm_wdata_d;
    end
  end

  assign ms_allowin_o    = (state_q == IDLE) || !rst_n;
  assign ms_valid_o      = ms_valid_q;
  assign ms_misalign_o   = ms_misalign_q;
  assign ms_mem_out_o    = ms_mem_out_q;
  assign ms_alu_result_o = ms_alu_q;
  assign ms_ctrl_o       = ms_ctrl_q;
  assign ms_rd_o         = ms_rd_q;
  assign dm_req_o        = dm_req_q;
  assign dm_we_o         = dm_we_q;
  assign dm_addr_o       = dm_addr_q;
  assign dm_wstrb_o      = dm_wstrb_q;
  assign dm_wdata_o      = dm_wdata_q;

endmodule
